// File: rtl/source_destination.sv
// Valid/ready word source plus in-order sink checker wrapped around a stage under test.
// Optional macro DST_BACKPRESSURE_EN makes the sink drop dst_ready one cycle in every eight.
module source_destination #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       s_rst,
    input  logic                       start,
    input  logic                       src_ready,
    output logic                       src_vaild,
    output logic [WIDTH-1:0]           src_data,
    input  logic                       dst_vaild,
    input  logic [WIDTH-1:0]           dst_data,
    output logic                       dst_ready,
    output logic                       src_done,
    output logic                       dst_done,
    output logic                       dst_err,
    output logic [$clog2(DEPTH+1)-1:0] dst_cnt
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    function automatic logic [WIDTH-1:0] to_word(input logic [CNT_W-1:0] idx);
        return WIDTH'(idx);
    endfunction

    // ---------------- source side ----------------
    logic [CNT_W-1:0] tx_idx;
    logic [CNT_W-1:0] tx_next;
    logic             src_hs;
    logic             last_word;
    logic             more_left;

    assign src_hs    = src_vaild & src_ready;
    assign tx_next   = tx_idx + CNT_W'(1);
    assign last_word = (tx_next == CNT_W'(DEPTH));
    assign more_left = (tx_idx < CNT_W'(DEPTH));

    // tx_idx always names the word currently presented (or the next one to launch).
    always_ff @(posedge clk or negedge s_rst) begin
        if (!s_rst) begin
            tx_idx    <= '0;
            src_vaild <= 1'b0;
            src_data  <= '0;
            src_done  <= 1'b0;
        end else if (src_hs) begin
            tx_idx <= tx_next;
            if (last_word) begin
                src_vaild <= 1'b0;
                src_done  <= 1'b1;
            end else if (start) begin
                src_vaild <= 1'b1;
                src_data  <= to_word(tx_next);
            end else begin
                src_vaild <= 1'b0;
            end
        end else if (!src_vaild && start && more_left) begin
            src_vaild <= 1'b1;
            src_data  <= to_word(tx_idx);
        end
    end

    // ---------------- sink side ----------------
    logic [WIDTH-1:0] exp;
    logic [CNT_W-1:0] cnt_next;
    logic             dst_hs;
    logic             done_next;
    logic             ready_next;

    assign dst_hs    = dst_vaild & dst_ready & ~dst_done;
    assign cnt_next  = dst_cnt + CNT_W'(1);
    assign done_next = dst_done | (dst_hs & (cnt_next == CNT_W'(DEPTH)));

`ifdef DST_BACKPRESSURE_EN
    logic [2:0] pc;
    logic [2:0] pc_next;

    assign pc_next    = pc + 3'd1;
    assign ready_next = (pc_next != 3'd7) & ~done_next;

    always_ff @(posedge clk or negedge s_rst) begin
        if (!s_rst) begin
            pc <= 3'd0;
        end else begin
            pc <= pc_next;
        end
    end
`else
    assign ready_next = ~done_next;
`endif

    // Expected value keeps advancing after a mismatch so one bad word flags only itself.
    always_ff @(posedge clk or negedge s_rst) begin
        if (!s_rst) begin
            exp       <= '0;
            dst_cnt   <= '0;
            dst_err   <= 1'b0;
            dst_done  <= 1'b0;
            dst_ready <= 1'b0;
        end else begin
            dst_ready <= ready_next;
            dst_done  <= done_next;
            if (dst_hs) begin
                exp     <= exp + WIDTH'(1);
                dst_cnt <= cnt_next;
                if (dst_data != exp) begin
                    dst_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_source_destination.sv
// Loopback bench for source_destination: source words scoreboarded, sink state checked against a reference model.
module tb_source_destination;

    localparam int WIDTH = 9;
    localparam int DEPTH = 256;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk      = 1'b0;
    logic             s_rst    = 1'b1;
    logic             start    = 1'b0;
    logic             ready_en = 1'b1;
    logic             flip     = 1'b0;
    logic             mon_en   = 1'b0;
    logic             src_ready, src_vaild, dst_vaild, dst_ready;
    logic             src_done, dst_done, dst_err;
    logic [WIDTH-1:0] src_data, dst_data;
    logic [CNT_W-1:0] dst_cnt;

    int               total = 0;
    int               bad   = 0;
    logic [WIDTH-1:0] sq[$];

    always #5 clk = ~clk;

    // The stage under test is a wire; ready_en models it stalling on both sides at once.
    assign src_ready = dst_ready & ready_en;
    assign dst_vaild = src_vaild & ready_en;
    assign dst_data  = (flip && src_data == WIDTH'(10)) ? (src_data ^ WIDTH'(1)) : src_data;

    source_destination #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .s_rst    (s_rst),
        .start    (start),
        .src_ready(src_ready),
        .src_vaild(src_vaild),
        .src_data (src_data),
        .dst_vaild(dst_vaild),
        .dst_data (dst_data),
        .dst_ready(dst_ready),
        .src_done (src_done),
        .dst_done (dst_done),
        .dst_err  (dst_err),
        .dst_cnt  (dst_cnt)
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference sink model and source monitor, evaluated away from the active edge.
    int               m_cnt;
    int               m_edges;
    logic [WIDTH-1:0] m_exp;
    logic             m_err, m_done, prev_pend, er;
    logic [WIDTH-1:0] prev_data, exp_w;

    always @(negedge clk) begin
        if (!s_rst) begin
            m_cnt     = 0;
            m_edges   = 0;
            m_exp     = '0;
            m_err     = 1'b0;
            m_done    = 1'b0;
            prev_pend = 1'b0;
        end else if (mon_en) begin
`ifdef DST_BACKPRESSURE_EN
            er = (m_edges >= 1) && !m_done && ((m_edges % 8) != 7);
`else
            er = (m_edges >= 1) && !m_done;
`endif
            check("dst_cnt", int'(dst_cnt), m_cnt);
            check("dst_done", int'(dst_done), int'(m_done));
            check("dst_err", int'(dst_err), int'(m_err));
            check("dst_ready", int'(dst_ready), int'(er));
            if (prev_pend) begin
                check("hold_vaild", int'(src_vaild), 1);
                check("hold_data", int'(src_data), int'(prev_data));
            end
            if (src_vaild && src_ready) begin
                total++;
                if (sq.size() == 0) begin
                    bad++;
                    $display("FAIL src_word: got %0d but no word expected", src_data);
                end else begin
                    exp_w = sq.pop_front();
                    if (src_data != exp_w) begin
                        bad++;
                        $display("FAIL src_word: got %0d expected %0d", src_data, exp_w);
                    end
                end
            end
            prev_pend = src_vaild && !src_ready;
            prev_data = src_data;
            if (dst_vaild && dst_ready && !m_done) begin
                if (dst_data != m_exp) m_err = 1'b1;
                m_exp = m_exp + WIDTH'(1);
                m_cnt++;
                if (m_cnt == DEPTH) m_done = 1'b1;
            end
            m_edges++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_rst    = 1'b0;
        start    = 1'b0;
        ready_en = 1'b1;
        flip     = 1'b0;
        #1;
        check("rst_src_vaild", int'(src_vaild), 0);
        check("rst_src_data", int'(src_data), 0);
        check("rst_dst_ready", int'(dst_ready), 0);
        check("rst_src_done", int'(src_done), 0);
        check("rst_dst_done", int'(dst_done), 0);
        check("rst_dst_err", int'(dst_err), 0);
        check("rst_dst_cnt", int'(dst_cnt), 0);
        tick();
        tick();
        sq.delete();
        for (int i = 0; i < DEPTH; i++) sq.push_back(WIDTH'(i));
        mon_en = 1'b1;
        s_rst  = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(src_done && dst_done) && n < budget) begin
            tick();
            n++;
        end
        check("done_in_budget", int'(src_done && dst_done), 1);
        check("final_cnt", int'(dst_cnt), DEPTH);
        check("words_left", sq.size(), 0);
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] held;
        tick();

        // Straight loopback streaming with start held high.
        do_reset();
        start = 1'b1;
`ifndef DST_BACKPRESSURE_EN
        repeat (DEPTH) tick();
        check("stream_cnt_pre", int'(dst_cnt), DEPTH - 1);
        check("stream_done_pre", int'(dst_done), 0);
        tick();
        check("stream_cnt", int'(dst_cnt), DEPTH);
        check("stream_dst_done", int'(dst_done), 1);
        check("stream_src_done", int'(src_done), 1);
`endif
        wait_done(1000);
        check("stream_err", int'(dst_err), 0);

        // start toggling 1(2),0(2),1(3),0(3),1.
        do_reset();
        start = 1'b1; repeat (2) tick();
        start = 1'b0; repeat (2) tick();
        start = 1'b1; repeat (3) tick();
        start = 1'b0; repeat (3) tick();
        start = 1'b1;
        wait_done(1000);
        check("pattern_err", int'(dst_err), 0);

        // Downstream stall for five cycles on word 20.
        do_reset();
        start = 1'b1;
        n = 0;
        while (!(src_vaild && src_data == WIDTH'(20)) && n < 100) begin
            tick();
            n++;
        end
        check("stall_reach", int'(src_data), 20);
        ready_en = 1'b0;
        held = src_data;
        repeat (5) begin
            tick();
            check("stall_vaild", int'(src_vaild), 1);
            check("stall_data", int'(src_data), int'(held));
        end
        ready_en = 1'b1;
        wait_done(1000);
        check("stall_err", int'(dst_err), 0);

        // Corrupt bit 0 of word 10 on the way to the sink.
        do_reset();
        flip  = 1'b1;
        start = 1'b1;
        wait_done(1000);
        check("flip_err", int'(dst_err), 1);

        // Reset after 100 words, then a full clean run.
        do_reset();
        start = 1'b1;
        n = 0;
        while (dst_cnt < CNT_W'(100) && n < 500) begin
            tick();
            n++;
        end
        check("mid_cnt", int'(dst_cnt), 100);
        do_reset();
        start = 1'b1;
        tick();
        check("restart_cnt", int'(dst_cnt), 0);
        check("restart_data", int'(src_data), 0);
        wait_done(1000);
        check("restart_err", int'(dst_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
